// File: rtl/prog_ram_loader_pkg.sv
// Shared definitions for the program RAM loader: state encoding and default geometry.
package prog_ram_loader_pkg;

  localparam int unsigned DefaultAddrW = 16;
  localparam int unsigned DefaultDataW = 8;

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StIdle  = 2'd1,
    StLoad  = 2'd2,
    StRun   = 2'd3
  } state_e;

endpackage

// File: rtl/spram_rar.sv
// Single-port RAM with registered-address read; a write to the latched address
// is visible on the read port in the same cycle it lands.
module spram_rar
  import prog_ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [Depth];
  logic [ADDR_W-1:0] r_addr;

  // Contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
    end else begin
      r_addr <= i_addr;
    end
  end

  assign o_rdata = r_mem[r_addr];

endmodule

// File: rtl/prog_ram_loader.sv
// Program RAM with post-reset zero fill, a streaming loader port and a CPU port;
// holds the CPU in reset except while running.
module prog_ram_loader
  import prog_ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = DefaultAddrW,
  parameter int unsigned DATA_W         = DefaultDataW,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_di,
  output logic              cpu_reset,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              run_req,
  input  logic              halt_req,
  output logic [ADDR_W:0]   ld_count,
  output logic [1:0]        state
);

  localparam logic [ADDR_W:0] CountMax = {1'b1, {ADDR_W{1'b0}}};

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_d;
  logic [ADDR_W-1:0] r_ptr, w_ptr_d;
  logic [ADDR_W:0]   r_ld_count, w_ld_count_d;
  logic              r_cpu_reset;
  logic              w_hs;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  assign ld_ready = (r_state == StLoad);
  assign w_hs     = ld_valid && ld_ready;

  always_comb begin
    w_state_d    = r_state;
    w_clr_cnt_d  = r_clr_cnt;
    w_ptr_d      = r_ptr;
    w_ld_count_d = r_ld_count;
    w_addr       = cpu_ab;
    w_wdata      = cpu_dout;
    w_we         = 1'b0;
    unique case (r_state)
      StClear: begin
        w_addr      = r_clr_cnt;
        w_wdata     = '0;
        w_we        = 1'b1;
        w_clr_cnt_d = r_clr_cnt + 1'b1;
        if (&r_clr_cnt) begin
          w_state_d = StIdle;
        end
      end
      StIdle: begin
        // A simultaneous run request loses to a load request.
        if (ld_start) begin
          w_state_d    = StLoad;
          w_ptr_d      = ld_base;
          w_ld_count_d = '0;
        end else if (run_req) begin
          w_state_d = StRun;
        end
      end
      StLoad: begin
        w_addr  = r_ptr;
        w_wdata = ld_data;
        w_we    = w_hs;
        if (w_hs) begin
          w_ptr_d = r_ptr + 1'b1;
          if (r_ld_count != CountMax) begin
            w_ld_count_d = r_ld_count + 1'b1;
          end
          if (ld_last) begin
            w_state_d = StIdle;
          end
        end
      end
      StRun: begin
        w_we = cpu_we;
        if (halt_req) begin
          w_state_d = StIdle;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= CLEAR_ON_RESET ? StClear : StIdle;
      r_clr_cnt   <= '0;
      r_ptr       <= '0;
      r_ld_count  <= '0;
      r_cpu_reset <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_clr_cnt   <= w_clr_cnt_d;
      r_ptr       <= w_ptr_d;
      r_ld_count  <= w_ld_count_d;
      // Released one cycle after entering RUN, reasserted together with leaving it.
      r_cpu_reset <= !((r_state == StRun) && (w_state_d == StRun));
    end
  end

  spram_rar #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (cpu_di)
  );

  assign cpu_reset = r_cpu_reset;
  assign ld_count  = r_ld_count;
  assign state     = r_state;

endmodule

// File: tb/tb_prog_ram_loader.sv
// Bench for prog_ram_loader: a 4-bit instance for clear/saturation/reset cases and a
// 16-bit instance for loads, wrap, CPU access and randomized traffic against a model.
module tb_prog_ram_loader;

  localparam logic [1:0] SClear = 2'd0;
  localparam logic [1:0] SIdle  = 2'd1;
  localparam logic [1:0] SLoad  = 2'd2;
  localparam logic [1:0] SRun   = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 4-bit instance
  logic       rst4_n = 1'b0;
  logic [3:0] ab4 = '0, base4 = '0;
  logic [7:0] dout4 = '0, data4 = '0, di4;
  logic       we4 = 1'b0, ldst4 = 1'b0, lv4 = 1'b0, ll4 = 1'b0, run4 = 1'b0, halt4 = 1'b0;
  logic       cpurst4, lr4;
  logic [4:0] cnt4;
  logic [1:0] st4;

  // 16-bit instance
  logic        rst_n = 1'b0;
  logic [15:0] cpu_ab = '0, ld_base = '0;
  logic [7:0]  cpu_dout = '0, ld_data = '0, cpu_di;
  logic        cpu_we = 1'b0, ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic        run_req = 1'b0, halt_req = 1'b0;
  logic        cpu_reset, ld_ready;
  logic [16:0] ld_count;
  logic [1:0]  state;

  bit [7:0] ref_mem [bit [15:0]];

  prog_ram_loader #(.ADDR_W(4), .DATA_W(8), .CLEAR_ON_RESET(1'b1)) u_dut4 (
    .clk(clk), .reset_n(rst4_n), .cpu_ab(ab4), .cpu_dout(dout4), .cpu_we(we4), .cpu_di(di4),
    .cpu_reset(cpurst4), .ld_start(ldst4), .ld_base(base4), .ld_valid(lv4), .ld_ready(lr4),
    .ld_data(data4), .ld_last(ll4), .run_req(run4), .halt_req(halt4), .ld_count(cnt4),
    .state(st4)
  );

  prog_ram_loader #(.ADDR_W(16), .DATA_W(8), .CLEAR_ON_RESET(1'b0)) u_dut16 (
    .clk(clk), .reset_n(rst_n), .cpu_ab(cpu_ab), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
    .cpu_di(cpu_di), .cpu_reset(cpu_reset), .ld_start(ld_start), .ld_base(ld_base),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .run_req(run_req), .halt_req(halt_req), .ld_count(ld_count), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called with reset just released: expect exactly 16 CLEAR cycles, then IDLE.
  task automatic clear4_wait();
    chk("clr4_first", {30'd0, st4}, {30'd0, SClear});
    for (int i = 1; i < 16; i++) begin
      step();
      chk("clr4_state", {30'd0, st4}, {30'd0, SClear});
      chk("clr4_cpurst", {31'd0, cpurst4}, 32'd1);
    end
    step();
    chk("clr4_done", {30'd0, st4}, {30'd0, SIdle});
  endtask

  task automatic read4_all(input logic [7:0] exp, input string tag);
    for (int i = 0; i < 16; i++) begin
      ab4 = 4'(i);
      step();
      chk(tag, {24'd0, di4}, {24'd0, exp});
    end
  endtask

  task automatic read16(input bit [15:0] a);
    cpu_ab = a;
    step();
    if (ref_mem.exists(a)) chk("rd16", {24'd0, cpu_di}, {24'd0, ref_mem[a]});
  endtask

  task automatic verify_model();
    foreach (ref_mem[a]) read16(a);
  endtask

  task automatic do_load(input bit [15:0] base, input bit [7:0] bytes[$], input int gmax,
                         input bit with_run);
    int ngap;
    bit [15:0] a;
    ld_start = 1'b1;
    run_req  = with_run;
    ld_base  = base;
    step();
    ld_start = 1'b0;
    run_req  = 1'b0;
    chk("ld_enter", {30'd0, state}, {30'd0, SLoad});
    chk("ld_cpurst", {31'd0, cpu_reset}, 32'd1);
    chk("ld_cnt0", {15'd0, ld_count}, 32'd0);
    for (int i = 0; i < bytes.size(); i++) begin
      ngap = (gmax == 0) ? 0 : ((i == 1) ? 1 : int'($urandom_range(0, gmax)));
      for (int g = 0; g < ngap; g++) begin
        ld_valid = 1'b0;
        ld_data  = 8'($urandom);
        ld_last  = 1'($urandom);
        step();
        chk("gap_state", {30'd0, state}, {30'd0, SLoad});
        chk("gap_cnt", {15'd0, ld_count}, i);
      end
      ld_valid = 1'b1;
      ld_data  = bytes[i];
      ld_last  = (i == bytes.size() - 1);
      chk("ld_ready", {31'd0, ld_ready}, 32'd1);
      step();
      a = base + 16'(i);
      ref_mem[a] = bytes[i];
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("ld_exit", {30'd0, state}, {30'd0, SIdle});
    chk("ld_count", {15'd0, ld_count}, bytes.size());
    chk("ld_ready_off", {31'd0, ld_ready}, 32'd0);
  endtask

  task automatic run_session(input int ncyc);
    bit [15:0] a;
    run_req = 1'b1;
    step();
    run_req = 1'b0;
    chk("run_enter", {30'd0, state}, {30'd0, SRun});
    chk("run_cpurst_hi", {31'd0, cpu_reset}, 32'd1);
    for (int i = 0; i < ncyc; i++) begin
      a        = 16'h1300 + 16'($urandom_range(0, 15));
      cpu_ab   = a;
      cpu_we   = 1'($urandom);
      cpu_dout = 8'($urandom);
      step();
      if (cpu_we) ref_mem[a] = cpu_dout;
      if (ref_mem.exists(a)) chk("run_rd", {24'd0, cpu_di}, {24'd0, ref_mem[a]});
      chk("run_cpurst_lo", {31'd0, cpu_reset}, 32'd0);
    end
    cpu_we   = 1'b0;
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("halt_state", {30'd0, state}, {30'd0, SIdle});
    chk("halt_cpurst", {31'd0, cpu_reset}, 32'd1);
  endtask

  initial begin
    bit [7:0] q[$];
    bit [7:0] junk;
    int len;
    bit [15:0] base;

    // 4-bit: reset state, clear sequence, preset AA with saturating count, clear again
    repeat (2) step();
    chk("rst4_state", {30'd0, st4}, {30'd0, SClear});
    chk("rst4_cpurst", {31'd0, cpurst4}, 32'd1);
    chk("rst4_cnt", {27'd0, cnt4}, 32'd0);
    chk("rst4_ready", {31'd0, lr4}, 32'd0);
    chk("rst16_state", {30'd0, state}, {30'd0, SIdle});
    rst4_n = 1'b1;
    clear4_wait();
    read4_all(8'h00, "clr4_zero");
    ldst4 = 1'b1;
    base4 = 4'd0;
    step();
    ldst4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      lv4   = 1'b1;
      data4 = 8'hAA;
      ll4   = (i == 19);
      step();
    end
    lv4 = 1'b0;
    ll4 = 1'b0;
    chk("sat4_cnt", {27'd0, cnt4}, 32'd16);
    chk("sat4_state", {30'd0, st4}, {30'd0, SIdle});
    read4_all(8'hAA, "preset4");
    rst4_n = 1'b0;
    #1;
    chk("rst4b_state", {30'd0, st4}, {30'd0, SClear});
    step();
    rst4_n = 1'b1;
    clear4_wait();
    read4_all(8'h00, "reclr4_zero");

    // 4-bit: reset in the middle of a load
    ldst4 = 1'b1;
    base4 = 4'd3;
    step();
    ldst4 = 1'b0;
    lv4   = 1'b1;
    data4 = 8'h5A;
    step();
    data4 = 8'h5B;
    step();
    lv4 = 1'b0;
    chk("mid4_cnt", {27'd0, cnt4}, 32'd2);
    #2;
    rst4_n = 1'b0;
    #1;
    chk("mid4_state", {30'd0, st4}, {30'd0, SClear});
    chk("mid4_ready", {31'd0, lr4}, 32'd0);
    chk("mid4_cnt0", {27'd0, cnt4}, 32'd0);
    chk("mid4_cpurst", {31'd0, cpurst4}, 32'd1);
    step();
    rst4_n = 1'b1;
    clear4_wait();
    read4_all(8'h00, "mid4_zero");

    // 16-bit directed
    rst_n = 1'b1;
    step();
    chk("r16_state", {30'd0, state}, {30'd0, SIdle});
    chk("r16_cpurst", {31'd0, cpu_reset}, 32'd1);
    chk("r16_cnt", {15'd0, ld_count}, 32'd0);
    chk("r16_ready", {31'd0, ld_ready}, 32'd0);
    q = '{8'h38, 8'hA9, 8'h23, 8'h69, 8'h47};
    do_load(16'h0000, q, 2, 1'b0);
    repeat (3) step();
    chk("cnt_hold", {15'd0, ld_count}, 32'd5);
    q = '{8'h11, 8'h22, 8'h33};
    do_load(16'hFFFE, q, 0, 1'b0);
    verify_model();

    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("halt_idle_ign", {30'd0, state}, {30'd0, SIdle});

    run_req = 1'b1;
    step();
    run_req = 1'b0;
    chk("run36_state", {30'd0, state}, {30'd0, SRun});
    chk("run36_cpurst1", {31'd0, cpu_reset}, 32'd1);
    cpu_ab   = 16'h1300;
    cpu_dout = 8'h69;
    cpu_we   = 1'b1;
    step();
    cpu_we = 1'b0;
    ref_mem[16'h1300] = 8'h69;
    chk("run36_cpurst0", {31'd0, cpu_reset}, 32'd0);
    chk("run36_wr", {24'd0, cpu_di}, 32'h69);
    ld_start = 1'b1;
    run_req  = 1'b1;
    step();
    ld_start = 1'b0;
    run_req  = 1'b0;
    chk("run36_rdback", {24'd0, cpu_di}, 32'h69);
    chk("run36_ign", {30'd0, state}, {30'd0, SRun});
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("halt36_state", {30'd0, state}, {30'd0, SIdle});
    chk("halt36_cpurst", {31'd0, cpu_reset}, 32'd1);

    q = '{8'hC3};
    do_load(16'h2000, q, 0, 1'b1);

    // Randomized traffic against the model
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        len  = int'($urandom_range(1, 6));
        base = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                           : 16'h1300 + 16'($urandom_range(0, 15));
        q.delete();
        for (int i = 0; i < len; i++) begin
          junk = 8'($urandom);
          q.push_back(junk);
        end
        do_load(base, q, 2, 1'b0);
      end else begin
        run_session(int'($urandom_range(4, 10)));
      end
    end
    verify_model();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_ram_loader.md
PROG_RAM_LOADER -- requirements
Module: prog_ram_loader

Interface
REQ-001 SHALL take parameter ADDR_W, default 16: address width; depth is 2**ADDR_W words.
REQ-002 SHALL take parameter DATA_W, default 8: word width.
REQ-003 SHALL take parameter CLEAR_ON_RESET, default 1: 1 = zero-fill the whole array after reset; 0 = skip the fill.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 cpu_ab  in  ADDR_W  CPU address.
REQ-007 cpu_dout  in  DATA_W  CPU write data.
REQ-008 cpu_we  in  1  CPU write enable; honoured only in RUN.
REQ-009 cpu_di  out  DATA_W  read data to CPU.
REQ-010 cpu_reset  out  1  active-high reset to CPU core.
REQ-011 ld_start  in  1  one-cycle pulse; begins a load at ld_base.
REQ-012 ld_base  in  ADDR_W  load start address; sampled with ld_start.
REQ-013 ld_valid / ld_ready / ld_data[DATA_W] / ld_last  in/out/in/in  byte-stream loader handshake.
REQ-014 run_req  in  1  pulse; release CPU from reset.
REQ-015 halt_req  in  1  pulse; return CPU to reset.
REQ-016 ld_count  out  ADDR_W+1  words accepted in current/last load.
REQ-017 state  out  2  encoded FSM state (CLEAR=0, IDLE=1, LOAD=2, RUN=3).

Function
REQ-018 Array SHALL be single-port, 2**ADDR_W x DATA_W; at most one write per cycle.
REQ-019 Read SHALL use registered address: addr_reg <= active address every cycle; cpu_di = mem[addr_reg] combinationally, so a same-cycle write to addr_reg returns the new data.
REQ-020 Active address/write source SHALL be: CLEAR -> clear counter, data 0, write every cycle; LOAD -> load pointer, ld_data, write on ld_valid&&ld_ready; RUN -> cpu_ab/cpu_dout/cpu_we; IDLE -> cpu_ab, no write.
REQ-021 CLEAR SHALL write zero to addresses 0..2**ADDR_W-1, one per cycle, then go to IDLE the cycle after writing the last address (2**ADDR_W cycles total).
REQ-022 IDLE: ld_start -> LOAD (pointer <= ld_base, ld_count <= 0); else run_req -> RUN; ld_start wins if both are asserted.
REQ-023 LOAD: ld_ready SHALL be 1 throughout LOAD and 0 in all other states; each handshake writes at pointer, pointer increments modulo 2**ADDR_W (wrap FFFF->0000), ld_count increments.
REQ-024 LOAD: a handshake with ld_last=1 SHALL write that word and go to IDLE next cycle; ld_valid=0 cycles SHALL stall without side effects.
REQ-025 RUN: halt_req -> IDLE; run_req ignored.
REQ-026 ld_start SHALL be ignored outside IDLE; halt_req ignored outside RUN.
REQ-027 cpu_reset SHALL be registered: 0 in the cycle after RUN is entered and while in RUN; 1 in every other state.
REQ-028 ld_count SHALL saturate at 2**ADDR_W and hold its value until the next ld_start.

Reset
REQ-029 On reset_n low, asynchronously: state <= CLEAR if CLEAR_ON_RESET else IDLE; cpu_reset <= 1; clear counter, pointer, ld_count, addr_reg <= 0.
REQ-030 Array contents SHALL NOT be reset directly; reset mid-LOAD or mid-CLEAR SHALL abandon the operation, and CLEAR restarts from address 0.

Structure
REQ-031 Shared package SHALL hold the state enum encoding and the default ADDR_W/DATA_W constants.
REQ-032 One sub-module SHALL be used: spram_rar (parametrised single-port array with registered-address read); the FSM, counters and muxing stay at top level.

Verification
REQ-033 ADDR_W=4, CLEAR_ON_RESET=1, preset array to 8'hAA, reset -> state CLEAR for exactly 16 cycles, then IDLE; all words 0; cpu_reset=1 throughout.
REQ-034 IDLE, ld_start with ld_base=16'h0000, stream 38 A9 23 69 47 (last on 47) with valid gaps -> mem[0..4] equal the stream; ld_count=5; IDLE; no writes during gaps.
REQ-035 ld_base=16'hFFFE, stream 11 22 33 (last on 33) -> mem[FFFE]=11, mem[FFFF]=22, mem[0000]=33 (wrap).
REQ-036 run_req, then CPU writes 8'h69 to 16'h1300 and reads it back next cycle -> cpu_di=69; cpu_reset falls 1 cycle after RUN is entered; halt_req -> cpu_reset=1, state IDLE.
REQ-037 ld_start and run_req asserted together in IDLE -> LOAD; cpu_reset remains 1.
REQ-038 reset_n asserted mid-LOAD after 2 bytes -> async return to CLEAR; ld_ready=0 at once; ld_count=0.
